// File: rtl/accum_pkg.sv
// Shared types and defaults for the accumulator scheduler: FSM state encoding,
// default geometry and an ID-width helper that never returns zero.
package accum_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ACC_LEN = 3;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/accum_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr, wrapping.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any_req
);

  // Scan from the farthest offset down so the nearest request to ptr wins last.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        grant   = IW'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/accum_scheduler.sv
// Shared accumulator: locks one requester for ACC_LEN partials, emits sum+ID one cycle later.
// Holds emit (stable out_data/out_id, no accepts) while out_ready=0. ACCUM_SAT_EN adds saturation + sat_flag.
module accum_scheduler
  import accum_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int ACC_LEN = DEF_ACC_LEN,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     busy
`ifdef ACCUM_SAT_EN
  , output logic                   sat_flag
`endif
);

  localparam int CNT_W = id_width(ACC_LEN + 1);

  state_t           state, next_state;
  logic [ID_W-1:0]  grant_id, rr_ptr, arb_grant;
  logic             arb_any;
  logic [WIDTH-1:0] acc, acc_next, cur_data;
  logic [CNT_W-1:0] cnt;
  logic             xfer, last_xfer;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  assign cur_data  = req_data[int'(grant_id)*WIDTH +: WIDTH];
  assign xfer      = (state == ACCUM) && req_valid[grant_id];
  assign last_xfer = xfer && (cnt == CNT_W'(ACC_LEN - 1));

`ifdef ACCUM_SAT_EN
  logic [WIDTH:0] sum;
  logic           sat;
  assign sum = {1'b0, acc} + {1'b0, cur_data};
  // Once any add overflows, the rest of the sequence is pinned at full scale.
  assign acc_next = (sat || sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
`else
  assign acc_next = acc + cur_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (arb_any)   next_state = ACCUM;
      ACCUM:   if (last_xfer) next_state = EMIT;
      EMIT:    if (out_ready) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id <= '0;
      rr_ptr   <= '0;
      acc      <= '0;
      cnt      <= '0;
`ifdef ACCUM_SAT_EN
      sat      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) grant_id <= arb_grant;
          acc <= '0;
          cnt <= '0;
`ifdef ACCUM_SAT_EN
          sat <= 1'b0;
`endif
        end
        ACCUM: begin
          if (xfer) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
`ifdef ACCUM_SAT_EN
            if (sum[WIDTH]) sat <= 1'b1;
`endif
          end
        end
        EMIT: begin
          if (out_ready)
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == ACCUM) req_ready[grant_id] = 1'b1;
    out_valid = (state == EMIT);
    out_data  = out_valid ? acc : '0;
    out_id    = out_valid ? grant_id : '0;
    busy      = (state != IDLE);
`ifdef ACCUM_SAT_EN
    sat_flag  = out_valid && sat;
`endif
  end

endmodule

// File: tb/tb_accum_scheduler.sv
// Directed bench for accum_scheduler (default geometry plus an ACC_LEN=1 instance).
module tb_accum_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        busy;
  logic        sat_flag;

  logic [3:0]  v1, r1;
  logic [31:0] d1;
  logic        o1_valid, o1_ready;
  logic [7:0]  o1_data;
  logic [1:0]  o1_id;
  logic        busy1;
  logic        sat1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accum_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
`ifdef ACCUM_SAT_EN
    , .sat_flag (sat_flag)
`endif
  );

  accum_scheduler #(.ACC_LEN(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (v1),
    .req_ready (r1),
    .req_data  (d1),
    .out_valid (o1_valid),
    .out_ready (o1_ready),
    .out_data  (o1_data),
    .out_id    (o1_id),
    .busy      (busy1)
`ifdef ACCUM_SAT_EN
    , .sat_flag (sat1)
`endif
  );

`ifndef ACCUM_SAT_EN
  assign sat_flag = 1'b0;
  assign sat1     = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input int r, input logic [7:0] d);
    int   i;
    logic ok;
    ok = 1'b0;
    i  = 0;
    req_valid[r]        = 1'b1;
    req_data[r*8 +: 8]  = d;
    while (!ok && i < 50) begin
      if (req_ready[r]) ok = 1'b1;
      @(negedge clk);
      i++;
    end
    req_valid[r] = 1'b0;
    chk("send_accepted", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_out(input string tag, input logic [7:0] exp_data, input logic [1:0] exp_id);
    int i;
    i = 0;
    while (!out_valid && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_data"}, {24'b0, out_data}, {24'b0, exp_data});
    chk({tag, "_id"}, {30'b0, out_id}, {30'b0, exp_id});
  endtask

  initial begin
    int n1, n3, nout, i;
    logic bad3;

    reset = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;
    v1 = '0; d1 = '0; o1_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {28'b0, req_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", {24'b0, out_data}, 32'd0);
    chk("rst_out_id", {30'b0, out_id}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;

    // Single requester: 10+20+30
    @(negedge clk); req_data[7:0] = 8'd10; req_valid[0] = 1'b1;
    chk("t1_idle_ready", {28'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("t1_accum_ready", {28'b0, req_ready}, 32'd1);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    @(negedge clk); req_data[7:0] = 8'd20;
    @(negedge clk); req_data[7:0] = 8'd30;
    @(negedge clk); req_valid[0] = 1'b0;
    chk("t1_out_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_out_data", {24'b0, out_data}, 32'd60);
    chk("t1_out_id", {30'b0, out_id}, 32'd0);
    chk("t1_emit_ready", {28'b0, req_ready}, 32'd0);
    chk("t1_sat", {31'b0, sat_flag}, 32'd0);
    @(negedge clk);
    chk("t1_out_done", {31'b0, out_valid}, 32'd0);

    // Wrap / saturation: 200+100+10
    send(2, 8'd200); send(2, 8'd100); send(2, 8'd10);
`ifdef ACCUM_SAT_EN
    wait_out("t2", 8'd255, 2'd2);
    chk("t2_sat", {31'b0, sat_flag}, 32'd1);
`else
    wait_out("t2", 8'd54, 2'd2);
`endif
    @(negedge clk);

    // Round robin: req1 and req3 pending from reset
    reset = 1'b1;
    req_valid = 4'b1010; req_data = '0;
    req_data[15:8] = 8'd1; req_data[31:24] = 8'd5;
    @(negedge clk); reset = 1'b0;
    n1 = 0; n3 = 0; nout = 0; bad3 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (n1 == 3) req_valid[1] = 1'b0;
      if (n3 == 3) req_valid[3] = 1'b0;
      if (req_ready[1] && req_valid[1]) n1++;
      if (req_ready[3] && req_valid[3]) n3++;
      if (req_ready[3] && nout == 0) bad3 = 1'b1;
      if (out_valid) begin
        if (nout == 0) begin
          chk("t3_first_id", {30'b0, out_id}, 32'd1);
          chk("t3_first_data", {24'b0, out_data}, 32'd3);
        end else begin
          chk("t3_second_id", {30'b0, out_id}, 32'd3);
          chk("t3_second_data", {24'b0, out_data}, 32'd15);
        end
        nout++;
      end
    end
    chk("t3_outputs", nout, 32'd2);
    chk("t3_req3_locked_out", {31'b0, bad3}, 32'd0);

    // Backpressure with gapped partials
    out_ready = 1'b0;
    send(0, 8'd4); repeat (3) @(negedge clk);
    send(0, 8'd5); repeat (3) @(negedge clk);
    send(0, 8'd6);
    req_valid[1] = 1'b1; req_data[15:8] = 8'd9;
    for (int k = 0; k < 5; k++) begin
      chk("t4_valid", {31'b0, out_valid}, 32'd1);
      chk("t4_data", {24'b0, out_data}, 32'd15);
      chk("t4_id", {30'b0, out_id}, 32'd0);
      chk("t4_ready", {28'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1; req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t4_released", {31'b0, out_valid}, 32'd0);
    chk("t4_idle", {31'b0, busy}, 32'd0);

    // Reset mid-sequence
    send(0, 8'd1); send(0, 8'd2);
    chk("t5_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_ready", {28'b0, req_ready}, 32'd0);
    chk("t5_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_data", {24'b0, out_data}, 32'd0);
    chk("t5_id", {30'b0, out_id}, 32'd0);
    @(negedge clk); reset = 1'b0;
    send(0, 8'd1); send(0, 8'd2); send(0, 8'd3);
    wait_out("t5", 8'd6, 2'd0);
    @(negedge clk);

    // ACC_LEN=1 instance
    v1[0] = 1'b1; d1[7:0] = 8'd77;
    i = 0;
    while (!r1[0] && i < 10) begin
      @(negedge clk);
      i++;
    end
    chk("t6_ready", {31'b0, r1[0]}, 32'd1);
    @(negedge clk); v1[0] = 1'b0;
    chk("t6_valid", {31'b0, o1_valid}, 32'd1);
    chk("t6_data", {24'b0, o1_data}, 32'd77);
    chk("t6_id", {30'b0, o1_id}, 32'd0);
    chk("t6_sat", {31'b0, sat1}, 32'd0);
    @(negedge clk);
    chk("t6_done", {31'b0, o1_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
